// File: rtl/cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cpu_regfile
// Description : 6502 programmer-visible register file (A, X, Y, S, P) for the
//               NES CPU core. Feeds the ALU A operand and flags, latches ALU
//               results and flags back, and provides stack address/push byte.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile #(
    parameter logic [7:0] RESET_S = 8'hFD,
    parameter logic [7:0] RESET_P = 8'h04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  alu_res,
    input  logic [7:0]  alu_flag,
    input  logic [7:0]  din,
    input  logic [2:0]  wr_dst,
    input  logic        wr_flags,
    input  logic        p_load,
    input  logic [2:0]  flag_op,
    input  logic        sp_inc,
    input  logic        sp_dec,
    input  logic [1:0]  sel_a,
    input  logic        brk_push,
    output logic [7:0]  alu_a,
    output logic [7:0]  p_out,
    output logic [7:0]  p_push,
    output logic [15:0] stack_addr,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_x,
    output logic [7:0]  reg_y,
    output logic [7:0]  reg_s
);

    // Write destination codes; 0 and 5-7 write nothing
    localparam logic [2:0] c_DST_A = 3'd1;
    localparam logic [2:0] c_DST_X = 3'd2;
    localparam logic [2:0] c_DST_Y = 3'd3;
    localparam logic [2:0] c_DST_S = 3'd4;

    // Flag operation codes
    localparam logic [2:0] c_FOP_CLC = 3'd1;
    localparam logic [2:0] c_FOP_SEC = 3'd2;
    localparam logic [2:0] c_FOP_CLI = 3'd3;
    localparam logic [2:0] c_FOP_SEI = 3'd4;
    localparam logic [2:0] c_FOP_CLV = 3'd5;
    localparam logic [2:0] c_FOP_CLD = 3'd6;
    localparam logic [2:0] c_FOP_SED = 3'd7;

    // Bit positions inside the packed 6-bit flag store {N,V,D,I,Z,C}
    localparam int c_PF_C = 0;
    localparam int c_PF_I = 2;
    localparam int c_PF_D = 3;
    localparam int c_PF_V = 4;

    logic [7:0] r_a;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_s;
    logic [5:0] r_pf;     // stored flags {N,V,D,I,Z,C}; bits 5/4 of P are synthesised

    logic [5:0] w_pf_next;
    logic [7:0] w_s_next;
    logic [7:0] w_p_base;

    // Bits 5:4 of the flag sources have no storage behind them
    wire w_unused_bits = &{1'b0, alu_flag[5:4], din[5:4]};

    // Next flag value: ALU flags, then PLP/RTI data, then a single-bit flag op
    always_comb begin
        w_pf_next = r_pf;
        if (wr_flags) begin
            w_pf_next = {alu_flag[7:6], alu_flag[3:0]};
        end
        if (p_load) begin
            w_pf_next = {din[7:6], din[3:0]};
        end
        case (flag_op)
            c_FOP_CLC: w_pf_next[c_PF_C] = 1'b0;
            c_FOP_SEC: w_pf_next[c_PF_C] = 1'b1;
            c_FOP_CLI: w_pf_next[c_PF_I] = 1'b0;
            c_FOP_SEI: w_pf_next[c_PF_I] = 1'b1;
            c_FOP_CLV: w_pf_next[c_PF_V] = 1'b0;
            c_FOP_CLD: w_pf_next[c_PF_D] = 1'b0;
            c_FOP_SED: w_pf_next[c_PF_D] = 1'b1;
            default:   ;
        endcase
    end

    // Next stack pointer: an explicit S write beats inc/dec; inc+dec cancel
    always_comb begin
        w_s_next = r_s;
        if (wr_dst == c_DST_S) begin
            w_s_next = alu_res;
        end else if (sp_inc && !sp_dec) begin
            w_s_next = r_s + 8'd1;
        end else if (sp_dec && !sp_inc) begin
            w_s_next = r_s - 8'd1;
        end
    end

    // Register update on enabled cycles; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= 8'h00;
            r_x  <= 8'h00;
            r_y  <= 8'h00;
            r_s  <= RESET_S;
            r_pf <= {RESET_P[7:6], RESET_P[3:0]};
        end else if (en) begin
            case (wr_dst)
                c_DST_A: r_a <= alu_res;
                c_DST_X: r_x <= alu_res;
                c_DST_Y: r_y <= alu_res;
                default: ;
            endcase
            r_s  <= w_s_next;
            r_pf <= w_pf_next;
        end
    end

    // Read side: operand mux and assembled status bytes, all zero-latency
    always_comb begin
        case (sel_a)
            2'd0:    alu_a = r_a;
            2'd1:    alu_a = r_x;
            2'd2:    alu_a = r_y;
            default: alu_a = r_s;
        endcase
        w_p_base = {r_pf[5:4], 1'b1, 1'b0, r_pf[3:0]};
    end

    assign p_out      = w_p_base;
    assign p_push     = {w_p_base[7:5], brk_push, w_p_base[3:0]};
    assign stack_addr = {8'h01, r_s};
    assign reg_a      = r_a;
    assign reg_x      = r_x;
    assign reg_y      = r_y;
    assign reg_s      = r_s;

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_regfile
// Description : Directed-vector scoreboard bench for cpu_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_regfile;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  alu_res;
    logic [7:0]  alu_flag;
    logic [7:0]  din;
    logic [2:0]  wr_dst;
    logic        wr_flags;
    logic        p_load;
    logic [2:0]  flag_op;
    logic        sp_inc;
    logic        sp_dec;
    logic [1:0]  sel_a;
    logic        brk_push;
    logic [7:0]  alu_a;
    logic [7:0]  p_out;
    logic [7:0]  p_push;
    logic [15:0] stack_addr;
    logic [7:0]  reg_a;
    logic [7:0]  reg_x;
    logic [7:0]  reg_y;
    logic [7:0]  reg_s;

    cpu_regfile #(.RESET_S(8'hFD), .RESET_P(8'h04)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alu_res(alu_res), .alu_flag(alu_flag), .din(din),
        .wr_dst(wr_dst), .wr_flags(wr_flags), .p_load(p_load),
        .flag_op(flag_op), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .sel_a(sel_a), .brk_push(brk_push),
        .alu_a(alu_a), .p_out(p_out), .p_push(p_push),
        .stack_addr(stack_addr), .reg_a(reg_a), .reg_x(reg_x),
        .reg_y(reg_y), .reg_s(reg_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [7:0]  a, x, y, s, p, p_push, alu_a;
        logic [15:0] stack;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
        end
    endtask

    // Monitor: the DUT's outputs are valid mid-cycle; compare the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "reg_a",      {8'h00, reg_a},  {8'h00, e.a});
            chk(e.tag, "reg_x",      {8'h00, reg_x},  {8'h00, e.x});
            chk(e.tag, "reg_y",      {8'h00, reg_y},  {8'h00, e.y});
            chk(e.tag, "reg_s",      {8'h00, reg_s},  {8'h00, e.s});
            chk(e.tag, "p_out",      {8'h00, p_out},  {8'h00, e.p});
            chk(e.tag, "p_push",     {8'h00, p_push}, {8'h00, e.p_push});
            chk(e.tag, "alu_a",      {8'h00, alu_a},  {8'h00, e.alu_a});
            chk(e.tag, "stack_addr", stack_addr,      e.stack);
        end
    end

    task automatic drv(input logic e, input logic [2:0] dst, input logic [7:0] res,
                       input logic wf, input logic [7:0] af, input logic pl,
                       input logic [7:0] d, input logic [2:0] fop,
                       input logic inc, input logic dec);
        en = e; wr_dst = dst; alu_res = res; wr_flags = wf; alu_flag = af;
        p_load = pl; din = d; flag_op = fop; sp_inc = inc; sp_dec = dec;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push an expectation; the read-side mux/push-byte follow the current sel_a/brk_push
    task automatic expect_state(input string tag, input logic [7:0] a, input logic [7:0] x,
                                input logic [7:0] y, input logic [7:0] s, input logic [7:0] p);
        exp_t e;
        e.tag = tag; e.a = a; e.x = x; e.y = y; e.s = s; e.p = p;
        e.p_push = brk_push ? (p | 8'h10) : p;
        case (sel_a)
            2'd0:    e.alu_a = a;
            2'd1:    e.alu_a = x;
            2'd2:    e.alu_a = y;
            default: e.alu_a = s;
        endcase
        e.stack = {8'h01, s};
        q.push_back(e);
    endtask

    // One enabled operation followed by a mid-cycle check of the result
    task automatic op(input string tag, input logic [2:0] dst, input logic [7:0] res,
                      input logic wf, input logic [7:0] af, input logic pl,
                      input logic [7:0] d, input logic [2:0] fop, input logic inc,
                      input logic dec, input logic [7:0] ea, input logic [7:0] ex,
                      input logic [7:0] ey, input logic [7:0] es, input logic [7:0] ep);
        drv(1'b1, dst, res, wf, af, pl, d, fop, inc, dec);
        tick();
        idle();
        expect_state(tag, ea, ex, ey, es, ep);
        tick();
    endtask

    initial begin
        rst = 1'b1; sel_a = 2'd0; brk_push = 1'b0;
        idle();
        tick();
        rst = 1'b0;
        expect_state("reset", 8'h00, 8'h00, 8'h00, 8'hFD, 8'h24);
        tick();

        //  tag          dst   res    wf    af     pl    din    fop   inc   dec    A      X      Y      S      P
        op("load",      3'd1, 8'h80, 1'b1, 8'h84, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'hFD, 8'hA4);
        op("txs",       3'd4, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 8'hA4);
        op("sp_wrap_dn",3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hA4);
        op("sp_wrap_up",3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 8'hA4);
        op("s_wr_prio", 3'd4, 8'h40, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 8'h40, 8'hA4);
        op("sp_incdec", 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 8'h80, 8'h00, 8'h00, 8'h40, 8'hA4);
        op("pload_prio",3'd0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h40, 8'hEF);
        op("fop_prio",  3'd0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 3'd1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h40, 8'hEE);
        op("flags_c3",  3'd0, 8'h00, 1'b1, 8'hC3, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h40, 8'hE3);

        // Push byte with and without the B bit
        brk_push = 1'b1;
        expect_state("push_brk", 8'h80, 8'h00, 8'h00, 8'h40, 8'hE3);
        tick();
        brk_push = 1'b0;
        expect_state("push_nobrk", 8'h80, 8'h00, 8'h00, 8'h40, 8'hE3);
        tick();

        op("clc",       3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h40, 8'hE2);

        // Enable gating: the same controls with en low change nothing
        drv(1'b0, 3'd2, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        idle();
        expect_state("en_gated", 8'h80, 8'h00, 8'h00, 8'h40, 8'hE2);
        tick();
        op("en_active", 3'd2, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1, 8'h80, 8'h55, 8'h00, 8'h3F, 8'hE3);

        sel_a = 2'd2;
        op("wr_y",      3'd3, 8'h12, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 8'h55, 8'h12, 8'h3F, 8'hE3);
        sel_a = 2'd1;
        expect_state("sel_x", 8'h80, 8'h55, 8'h12, 8'h3F, 8'hE3);
        tick();
        sel_a = 2'd3;
        expect_state("sel_s", 8'h80, 8'h55, 8'h12, 8'h3F, 8'hE3);
        tick();
        sel_a = 2'd0;
        op("reserved5", 3'd5, 8'h99, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 8'h55, 8'h12, 8'h3F, 8'hE3);
        op("reserved7", 3'd7, 8'h99, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h80, 8'h55, 8'h12, 8'h3F, 8'hE3);

        // PLA-style combined cycle: reads before the edge still show old values
        drv(1'b1, 3'd1, 8'h7E, 1'b1, 8'h02, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        expect_state("pla_old", 8'h80, 8'h55, 8'h12, 8'h3F, 8'hE3);
        tick();
        idle();
        expect_state("pla_new", 8'h7E, 8'h55, 8'h12, 8'h40, 8'h22);
        tick();

        op("sei",       3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 8'h7E, 8'h55, 8'h12, 8'h40, 8'h26);
        op("sed",       3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0, 8'h7E, 8'h55, 8'h12, 8'h40, 8'h2E);
        op("cli",       3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h7E, 8'h55, 8'h12, 8'h40, 8'h2A);
        op("cld",       3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0, 8'h7E, 8'h55, 8'h12, 8'h40, 8'h22);
        op("set_v",     3'd0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h7E, 8'h55, 8'h12, 8'h40, 8'h60);
        op("clv",       3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, 8'h7E, 8'h55, 8'h12, 8'h40, 8'h20);

        // Reset during an enabled update discards that update
        rst = 1'b1;
        drv(1'b1, 3'd1, 8'hFF, 1'b1, 8'hFF, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        expect_state("reset_mid", 8'h00, 8'h00, 8'h00, 8'hFD, 8'h24);
        tick();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
